// File: rtl/snake_body_if.sv
// snake_body_if: step/draw handshake between direction control, body engine and plotter
interface snake_body_if #(parameter int X_W = 8, parameter int Y_W = 7);
  logic step;
  logic [1:0] dir;
  logic grow;
  logic plot;
  logic [X_W-1:0] out_x;
  logic [Y_W-1:0] out_y;
  logic [2:0] colour;
  logic busy;
  logic [4:0] length;
  logic game_over;
  modport master (output step, dir, grow, input plot, out_x, out_y, colour, busy, length, game_over);
  modport slave (input step, dir, grow, output plot, out_x, out_y, colour, busy, length, game_over);
endinterface

// File: rtl/snake_body_engine.sv
// snake_body_engine: snake segment store with per-step erase/move/draw sequencing and collision detection
module snake_body_engine #(
  parameter int X_W = 8,
  parameter int Y_W = 7,
  parameter int MAX_LEN = 16,
  parameter int INIT_LEN = 3,
  parameter int START_X = 80,
  parameter int START_Y = 60,
  parameter int SCR_W = 160,
  parameter int SCR_H = 120,
  parameter int WRAP = 1,
  parameter logic [2:0] HEAD_COL = 3'b010
) (
  input logic clk,
  input logic resetn,
  snake_body_if.slave bus
);
  localparam int IW = $clog2(MAX_LEN);
  localparam logic [2:0] IDLE = 3'd0, ERASE = 3'd1, MOVE = 3'd2, DRAW = 3'd3, CHECK = 3'd4, DEAD = 3'd5;
  logic [2:0] state;
  logic [X_W-1:0] seg_x [MAX_LEN];
  logic [Y_W-1:0] seg_y [MAX_LEN];
  logic [4:0] len;
  logic [1:0] heading;
  logic grow_pend, grow_act, wall, hit, nwall, grow_eff;
  logic [X_W-1:0] nx;
  logic [Y_W-1:0] ny;
  logic [IW-1:0] tail;
  assign grow_eff = grow_pend | bus.grow;
  assign tail = IW'(len - 5'd1);
  assign bus.busy = (state != IDLE) && (state != DEAD);
  assign bus.length = len;
  // next head tile for the latched heading, and whether it leaves the field
  always_comb begin
    nx = heading == 2'd0 ? (seg_x[0] == X_W'(SCR_W - 1) ? '0 : seg_x[0] + 1'b1) :
         heading == 2'd2 ? (seg_x[0] == '0 ? X_W'(SCR_W - 1) : seg_x[0] - 1'b1) : seg_x[0];
    ny = heading == 2'd1 ? (seg_y[0] == Y_W'(SCR_H - 1) ? '0 : seg_y[0] + 1'b1) :
         heading == 2'd3 ? (seg_y[0] == '0 ? Y_W'(SCR_H - 1) : seg_y[0] - 1'b1) : seg_y[0];
    nwall = (WRAP == 0) && ((heading == 2'd0 && seg_x[0] == X_W'(SCR_W - 1)) ||
                            (heading == 2'd2 && seg_x[0] == '0) ||
                            (heading == 2'd1 && seg_y[0] == Y_W'(SCR_H - 1)) ||
                            (heading == 2'd3 && seg_y[0] == '0));
  end
  // head against every live body segment behind it
  always_comb begin
    hit = 1'b0;
    for (int i = 1; i < MAX_LEN; i++)
      hit = hit | (i < int'(len) && seg_x[i] == seg_x[0] && seg_y[i] == seg_y[0]);
  end
  // step sequencer: erase tail, shift body, draw head, check collision
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      for (int i = 0; i < MAX_LEN; i++) begin
        seg_x[i] <= i < INIT_LEN ? X_W'(START_X - i) : '0;
        seg_y[i] <= i < INIT_LEN ? Y_W'(START_Y) : '0;
      end
      len <= 5'(INIT_LEN);
      heading <= 2'd0;
      grow_pend <= 1'b0;
      grow_act <= 1'b0;
      wall <= 1'b0;
      bus.plot <= 1'b0;
      bus.out_x <= '0;
      bus.out_y <= '0;
      bus.colour <= 3'b000;
      bus.game_over <= 1'b0;
    end else begin
      bus.plot <= 1'b0;
      if (state != DEAD) grow_pend <= grow_pend | bus.grow;
      case (state)
        IDLE: if (bus.step && !bus.game_over) begin
          state <= ERASE;
          heading <= (bus.dir ^ heading) == 2'd2 ? heading : bus.dir;
          grow_act <= grow_eff;
          grow_pend <= 1'b0;
          bus.plot <= !grow_eff || len == 5'(MAX_LEN);
          bus.out_x <= seg_x[tail];
          bus.out_y <= seg_y[tail];
          bus.colour <= 3'b000;
        end
        ERASE: state <= MOVE;
        MOVE: begin
          state <= DRAW;
          wall <= nwall;
          if (!nwall) begin
            for (int i = MAX_LEN - 1; i > 0; i--) begin
              seg_x[i] <= seg_x[i-1];
              seg_y[i] <= seg_y[i-1];
            end
            seg_x[0] <= nx;
            seg_y[0] <= ny;
            if (grow_act && len < 5'(MAX_LEN)) len <= len + 5'd1;
            bus.plot <= 1'b1;
            bus.out_x <= nx;
            bus.out_y <= ny;
            bus.colour <= HEAD_COL;
          end
        end
        DRAW: state <= CHECK;
        CHECK: begin
          state <= (hit || wall) ? DEAD : IDLE;
          bus.game_over <= hit || wall;
        end
        default: state <= DEAD;
      endcase
    end
  end
endmodule

// File: tb/tb_snake_body_engine.sv
// tb_snake_body_engine: random step/grow stimulus against a queue-based body model, plus a wall-mode run
module tb_snake_body_engine;
  localparam int MAX = 16, W = 160, H = 120;
  logic clk = 0;
  logic resetn = 0;
  always #5 clk = ~clk;
  snake_body_if bus ();
  snake_body_if bw ();
  snake_body_engine dut (.clk(clk), .resetn(resetn), .bus(bus));
  snake_body_engine #(.WRAP(0)) wdut (.clk(clk), .resetn(resetn), .bus(bw));
  int checks = 0, errors = 0;
  logic [17:0] exq [$];
  logic [17:0] e;
  int bx [$], by [$];
  int mlen, hd, busy_cnt, n_acc = 0, dead_cnt = 0, wplots = 0, wbase;
  bit pend, coll, go_exp, rst_pending = 0, allow_rst = 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic model_init();
    bx = {80, 79, 78};
    by = {60, 60, 60};
    mlen = 3; hd = 0; pend = 0; coll = 0; go_exp = 0; busy_cnt = 0;
    exq.delete();
  endtask

  task automatic accept(input int d, input bit gr);
    bit g;
    int nx, ny;
    g = pend | gr;
    pend = 0;
    if (((d - hd) & 3) != 2) hd = d;
    if (!g || mlen == MAX) exq.push_back({8'(bx[mlen-1]), 7'(by[mlen-1]), 3'b000});
    nx = (bx[0] + (hd == 0 ? 1 : hd == 2 ? -1 : 0) + W) % W;
    ny = (by[0] + (hd == 1 ? 1 : hd == 3 ? -1 : 0) + H) % H;
    bx.push_front(nx);
    by.push_front(ny);
    if (g && mlen < MAX) mlen++;
    else begin
      void'(bx.pop_back());
      void'(by.pop_back());
    end
    exq.push_back({8'(nx), 7'(ny), 3'b010});
    coll = 0;
    for (int i = 1; i < mlen; i++) if (bx[i] == nx && by[i] == ny) coll = 1;
  endtask

  task automatic do_reset();
    resetn = 0;
    bus.step = 0; bus.grow = 0;
    model_init();
    rst_pending = 0;
    @(negedge clk);
    chk("reset_state", {bus.length, bus.busy, bus.plot, bus.game_over, bus.out_x, bus.out_y, bus.colour},
        {5'd3, 1'b0, 1'b0, 1'b0, 8'd0, 7'd0, 3'd0});
    resetn = 1;
  endtask

  task automatic cycle(input bit st, input bit [1:0] d, input bit gr);
    @(negedge clk);
    chk("busy", bus.busy, busy_cnt > 0);
    chk("game_over", bus.game_over, go_exp);
    if (busy_cnt == 0) chk("length", bus.length, mlen);
    if (rst_pending) begin
      do_reset();
      return;
    end
    bus.step = st; bus.dir = d; bus.grow = gr;
    if (st && busy_cnt == 0 && !go_exp) begin
      accept(d, gr);
      busy_cnt = 4;
      n_acc++;
      if (allow_rst && n_acc % 9 == 0) rst_pending = 1;
    end else begin
      if (busy_cnt > 0) begin
        busy_cnt--;
        if (busy_cnt == 0 && coll) go_exp = 1;
      end
      if (!go_exp) pend |= gr;
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (bus.plot === 1'b1) begin
      if (exq.size() == 0) chk("plot_unexpected", {bus.out_x, bus.out_y, bus.colour}, 18'h3ffff);
      else begin
        e = exq.pop_front();
        chk("plot", {bus.out_x, bus.out_y, bus.colour}, e);
      end
    end
  end

  always @(negedge clk) if (bw.plot === 1'b1) wplots++;

  initial begin
    bus.step = 0; bus.dir = 0; bus.grow = 0;
    bw.step = 0; bw.dir = 0; bw.grow = 0;
    @(negedge clk);
    do_reset();
    cycle(1, 2'd0, 0);
    for (int c = 0; c < 3000; c++) begin
      if (go_exp && ++dead_cnt > 8) begin
        dead_cnt = 0;
        do_reset();
      end
      cycle($urandom_range(0, 2) == 0, 2'($urandom_range(0, 3)), $urandom_range(0, 5) == 0);
    end
    repeat (6) cycle(0, 2'd0, 0);
    allow_rst = 0;
    do_reset();
    repeat (600) cycle(1, 2'd0, 0);
    repeat (420) cycle(1, 2'd3, 0);
    repeat (6) cycle(0, 2'd0, 0);
    chk("queue_drain", exq.size(), 0);
    wbase = wplots;
    for (int n = 0; n < 80; n++) begin
      @(negedge clk);
      if (n == 79) begin
        chk("wall_alive", bw.game_over, 1'b0);
        chk("wall_plots_before", wplots - wbase, 158);
      end
      bw.step = 1; bw.dir = 2'd0;
      @(negedge clk);
      bw.step = 0;
      repeat (5) @(negedge clk);
    end
    chk("wall_game_over", bw.game_over, 1'b1);
    chk("wall_no_head_plot", wplots - wbase, 159);
    chk("wall_length", bw.length, 5'd3);
    @(negedge clk);
    bw.step = 1;
    @(negedge clk);
    bw.step = 0;
    chk("dead_step_busy", bw.busy, 1'b0);
    repeat (4) @(negedge clk);
    chk("dead_step_plots", wplots - wbase, 159);
    chk("dead_sticky", bw.game_over, 1'b1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
